ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch stage that sits directly downstream of the PC register. Each cycle it reads the current PC and issues a single-outstanding request to instruction memory. It captures the 32-bit instruction into a one-entry output register for decode and drives the PC write port (pc+4, or a redirect target). It also handles redirect flush, drops in-flight stale responses and detects misaligned fetches.

Parameters:
XLEN, 64, PC/address width
INST_W, 32, instruction width
NOP_INST, 32'h00000013, instruction value presented on reset and on fault entries

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pc_rdata  in  XLEN  current PC from PC register
pc_wen  out  1  PC write enable (combinational; sampled by PC on clk edge)
pc_wdata  out  XLEN  next PC value
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc_rdata)
imem_resp_valid  in  1  response valid (always accepted)
imem_resp_data  in  INST_W  fetched instruction
if_valid  out  1  output entry valid to decode
if_ready  in  1  decode accepts entry
if_pc  out  XLEN  PC of output entry
if_inst  out  INST_W  instruction of output entry
if_fault  out  1  entry is a misaligned-fetch fault

Behaviour:
- States: REQ, WAIT, DRAIN, FAULT. Reset state is REQ.
- Async reset values: if_valid=0, if_fault=0, if_pc=0, if_inst=NOP_INST. pc_wen=0 and imem_req_valid=0 while rst is high.
- slot_free = !if_valid || if_ready. An entry is consumed when if_valid && if_ready; the consume clears if_valid unless a new entry loads the same cycle.
- REQ, pc_rdata[1:0]==0: imem_req_valid = slot_free; imem_req_addr = pc_rdata; request PC is latched on handshake.
  - Handshake (valid && ready) -> WAIT.
- REQ, pc_rdata[1:0]!=0: no request issued. When slot_free, load the output entry with if_fault=1, if_pc=pc_rdata, if_inst=NOP_INST, then go to FAULT. PC is not advanced.
- WAIT: on imem_resp_valid, load the output entry with if_pc=latched request PC, if_inst=resp_data, if_fault=0.
  - Same cycle: pc_wen=1, pc_wdata = latched PC + 4 (mod 2^XLEN, wraps); next state REQ.
- Latency: the request handshake at cycle T with the response at T+1 gives if_valid at T+2. A pc_wen issued in cycle T is visible on pc_rdata at T+1, so REQ always uses the updated PC.
- FAULT: hold the entry until consumed; afterwards if_valid stays 0. Remain in FAULT until a redirect.
- Redirect (highest priority, any state): pc_wen=1, pc_wdata=redirect_pc. On the next edge if_valid=0, regardless of if_ready or a same-cycle response.
  - REQ with a same-cycle request handshake -> DRAIN.
  - REQ without handshake -> REQ.
  - WAIT with a same-cycle resp_valid -> the response is dropped, next state REQ.
  - WAIT without response -> DRAIN.
  - DRAIN or FAULT -> REQ, except DRAIN without a response stays in DRAIN.
- DRAIN: no requests; the first imem_resp_valid is discarded (no entry load, no pc_wen) -> REQ.
- imem_resp_valid in REQ or FAULT is ignored (for example, a stale response after reset).
- Only one request is outstanding at any time. Output entry fields are stable while if_valid && !if_ready.
- Reset mid-operation: all state clears immediately (asynchronous); the memory-side outstanding response is ignored by the REQ rule above.

Test Plan:
- Reset, pc_rdata=0x80000000, req_ready=1, response 1 cycle later with 0x00000297 -> imem_req_addr=0x80000000. When the response arrives: pc_wen=1 with pc_wdata=0x80000004. One cycle later: if_valid=1, if_pc=0x80000000, if_inst=0x00000297.
- Backpressure: if_ready=0 for 3 cycles with an entry held -> imem_req_valid=0 and if_* stable. Raising if_ready -> same-cycle request at 0x80000004.
- Redirect to 0x80000100 during WAIT, response 2 cycles later -> response dropped, no pc_wen for it, if_valid stays 0. Next request addr=0x80000100.
- Redirect and imem_resp_valid in the same WAIT cycle -> pc_wdata=0x80000100, no entry loaded, request at 0x80000100 on the following cycle (no DRAIN).
- Redirect to 0x80000102 -> no imem request. Entry shows if_fault=1, if_pc=0x80000102, if_inst=0x00000013. After consume, no further entries until a redirect to 0x80000200 produces a request at 0x80000200.
- rst pulsed asynchronously mid-WAIT, response arrives after release -> outputs at reset values immediately. Late response ignored; a fresh request issues from the current pc_rdata.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry output
// register to decode, PC advance/redirect, stale-response drop and misalignment faults.
module ifetch_unit #(
    parameter int                 XLEN     = 64,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_rdata,
    output logic              pc_wen,
    output logic [XLEN-1:0]   pc_wdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_fault
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_FAULT} state_t;

    state_t          state;
    logic [XLEN-1:0] req_pc;
    logic            slot_free;
    logic            aligned;
    logic            req_fire;
    logic            consume;

    always_comb begin
        slot_free      = !if_valid || if_ready;
        aligned        = (pc_rdata[1:0] == 2'b00);
        consume        = if_valid && if_ready;
        imem_req_addr  = pc_rdata;
        imem_req_valid = !rst && (state == S_REQ) && aligned && slot_free;
        req_fire       = imem_req_valid && imem_req_ready;
        pc_wen         = 1'b0;
        pc_wdata       = req_pc + XLEN'(4);
        if (!rst) begin
            // A redirect always wins the PC write port over a sequential advance.
            if (redirect_valid) begin
                pc_wen   = 1'b1;
                pc_wdata = redirect_pc;
            end else if (state == S_WAIT && imem_resp_valid) begin
                pc_wen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            req_pc   <= '0;
            if_valid <= 1'b0;
            if_fault <= 1'b0;
            if_pc    <= '0;
            if_inst  <= NOP_INST;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            unique case (state)
                S_REQ:   state <= req_fire ? S_DRAIN : S_REQ;
                S_WAIT:  state <= imem_resp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state <= imem_resp_valid ? S_REQ : S_DRAIN;
                S_FAULT: state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            if (consume) begin
                if_valid <= 1'b0;
            end
            unique case (state)
                S_REQ: begin
                    if (!aligned) begin
                        if (slot_free) begin
                            if_valid <= 1'b1;
                            if_fault <= 1'b1;
                            if_pc    <= pc_rdata;
                            if_inst  <= NOP_INST;
                            state    <= S_FAULT;
                        end
                    end else if (req_fire) begin
                        req_pc <= pc_rdata;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The request was only issued with a free slot, so the entry is empty here.
                    if (imem_resp_valid) begin
                        if_valid <= 1'b1;
                        if_fault <= 1'b0;
                        if_pc    <= req_pc;
                        if_inst  <= imem_resp_data;
                        state    <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state <= S_REQ;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: models the PC register, drives imem responses
// by hand and scoreboards every entry accepted by decode.
module tb_ifetch_unit;

    localparam int XLEN = 64;
    localparam int INST_W = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [XLEN-1:0]   pc_reg;
    logic              pc_wen;
    logic [XLEN-1:0]   pc_wdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              if_valid;
    logic              if_ready;
    logic [XLEN-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_fault;
    logic              pc_load;
    logic [XLEN-1:0]   pc_load_val;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t sb[$];

    ifetch_unit #(.XLEN(XLEN), .INST_W(INST_W), .NOP_INST(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_rdata        (pc_reg),
        .pc_wen          (pc_wen),
        .pc_wdata        (pc_wdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_fault        (if_fault)
    );

    always #5 clk = ~clk;

    // PC register model; pc_load lets the bench preset the PC.
    always @(posedge clk) begin
        if (pc_load)     pc_reg <= pc_load_val;
        else if (pc_wen) pc_reg <= pc_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Accepted entries are compared against the scoreboard half a cycle before the edge.
    always @(negedge clk) begin
        if (!rst && if_valid && if_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("entry_pc", if_pc, e.pc);
                chk("entry_inst", {32'h0, if_inst}, {32'h0, e.inst});
                chk("entry_fault", {63'h0, if_fault}, {63'h0, e.fault});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held_pc;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        if_ready = 1'b1; pc_load = 1'b1; pc_load_val = 64'h8000_0000;
        cyc(); cyc();
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_pc_wen", {63'h0, pc_wen}, 64'h0);
        chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rst_if_inst", {32'h0, if_inst}, {32'h0, NOP});
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_fault", {63'h0, if_fault}, 64'h0);

        // Basic fetch
        rst = 1'b0; pc_load = 1'b0;
        settle();
        chk("t1_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0297;
        sb.push_back('{pc: 64'h8000_0000, inst: 32'h0000_0297, fault: 1'b0});
        settle();
        chk("t1_pc_wen", {63'h0, pc_wen}, 64'h1);
        chk("t1_pc_wdata", pc_wdata, 64'h8000_0004);
        cyc();
        imem_resp_valid = 1'b0; if_ready = 1'b0;
        settle();
        chk("t1_if_valid", {63'h0, if_valid}, 64'h1);
        chk("t1_if_pc", if_pc, 64'h8000_0000);
        chk("t1_if_inst", {32'h0, if_inst}, 64'h0000_0297);

        // Backpressure
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", {63'h0, imem_req_valid}, 64'h0);
            chk("bp_if_pc", if_pc, 64'h8000_0000);
            chk("bp_if_inst", {32'h0, if_inst}, 64'h0000_0297);
            cyc();
        end
        if_ready = 1'b1;
        settle();
        chk("bp_release_req", {63'h0, imem_req_valid}, 64'h1);
        chk("bp_release_addr", imem_req_addr, 64'h8000_0004);
        cyc();

        // Redirect during WAIT, late response drained
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        settle();
        chk("rw_pc_wen", {63'h0, pc_wen}, 64'h1);
        chk("rw_pc_wdata", pc_wdata, 64'h8000_0100);
        cyc();
        redirect_valid = 1'b0;
        settle();
        chk("drain_no_req", {63'h0, imem_req_valid}, 64'h0);
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        settle();
        chk("drain_no_pc_wen", {63'h0, pc_wen}, 64'h0);
        cyc();
        imem_resp_valid = 1'b0;
        settle();
        chk("drain_if_valid", {63'h0, if_valid}, 64'h0);
        chk("drain_next_req", {63'h0, imem_req_valid}, 64'h1);
        chk("drain_next_addr", imem_req_addr, 64'h8000_0100);
        cyc();

        // Redirect with a same-cycle response in WAIT
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
        settle();
        chk("rr_pc_wdata", pc_wdata, 64'h8000_0100);
        cyc();
        redirect_valid = 1'b0; imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
        settle();
        chk("rr_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rr_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("rr_req_addr", imem_req_addr, 64'h8000_0100);
        cyc();

        // Misaligned redirect -> fault entry
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        cyc();
        redirect_valid = 1'b0; if_ready = 1'b0;
        settle();
        chk("mis_no_req", {63'h0, imem_req_valid}, 64'h0);
        sb.push_back('{pc: 64'h8000_0102, inst: NOP, fault: 1'b1});
        cyc();
        chk("mis_if_valid", {63'h0, if_valid}, 64'h1);
        chk("mis_if_fault", {63'h0, if_fault}, 64'h1);
        chk("mis_if_pc", if_pc, 64'h8000_0102);
        chk("mis_if_inst", {32'h0, if_inst}, {32'h0, NOP});
        if_ready = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk("fault_idle_valid", {63'h0, if_valid}, 64'h0);
            chk("fault_idle_req", {63'h0, imem_req_valid}, 64'h0);
            cyc();
        end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; imem_req_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        settle();
        chk("fault_exit_req", {63'h0, imem_req_valid}, 64'h1);
        chk("fault_exit_addr", imem_req_addr, 64'h8000_0200);
        cyc();

        // Asynchronous reset in the middle of WAIT
        rst = 1'b1; pc_load = 1'b1; pc_load_val = 64'h8000_0300;
        settle();
        chk("arst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("arst_pc_wen", {63'h0, pc_wen}, 64'h0);
        chk("arst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("arst_if_pc", if_pc, 64'h0);
        cyc();
        rst = 1'b0; pc_load = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD_0BAD;
        settle();
        chk("late_resp_no_wen", {63'h0, pc_wen}, 64'h0);
        cyc();
        imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
        settle();
        chk("late_if_valid", {63'h0, if_valid}, 64'h0);
        chk("fresh_req", {63'h0, imem_req_valid}, 64'h1);
        chk("fresh_addr", imem_req_addr, 64'h8000_0300);
        cyc();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0073;
        sb.push_back('{pc: 64'h8000_0300, inst: 32'h0010_0073, fault: 1'b0});
        settle();
        chk("fresh_pc_wdata", pc_wdata, 64'h8000_0304);
        cyc();
        imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
        settle();
        chk("fresh_if_valid", {63'h0, if_valid}, 64'h1);
        cyc();

        // PC increment wraps at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        settle();
        chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0001;
        sb.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, inst: 32'h0000_0001, fault: 1'b0});
        settle();
        chk("wrap_pc_wdata", pc_wdata, 64'h0);
        cyc();
        imem_resp_valid = 1'b0;
        held_pc = if_pc;
        cyc(); cyc();
        chk("wrap_pc_reg", pc_reg, 64'h0);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
